// File: rtl/serializer_pmode.sv
// Parallel-to-serial converter: DataWidth-bit words out over Lanes lines, Beats per word,
// each beat held ClkDiv cycles, with a one-entry hold register for gapless back-to-back words.
module serializer_pmode #(
  parameter int DataWidth = 8,
  parameter int Lanes     = 1,
  parameter int ClkDiv    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 lsb_first_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic [Lanes-1:0]     data_o,
  output logic                 ena_o,
  output logic                 done_o
);

  localparam int Beats = DataWidth / Lanes;
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int DivW  = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  localparam logic [BeatW-1:0] BeatLast = BeatW'(Beats - 1);
  localparam logic [BeatW-1:0] BeatOne  = BeatW'(1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(ClkDiv - 1);
  localparam logic [DivW-1:0]  DivOne   = DivW'(1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [DataWidth-1:0] word_q, word_d;
  logic                 lsb_q, lsb_d;
  logic [BeatW-1:0]     beat_q, beat_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [DataWidth-1:0] hold_q, hold_d;
  logic                 hold_lsb_q, hold_lsb_d;
  logic                 hold_full_q, hold_full_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [Lanes-1:0]     data_q, data_d;
  logic                 ena_q, ena_d;
  logic                 done_q, done_d;

  logic accept;
  logic last_cycle;
  logic hold_move;

  // Beat k of a word: shifting brings the wanted slice to the top (MSB-first) or bottom (LSB-first).
  function automatic logic [Lanes-1:0] beat_of(input logic [DataWidth-1:0] w,
                                               input logic lsb,
                                               input logic [BeatW-1:0] k);
    logic [DataWidth-1:0] sr;
    logic [DataWidth-1:0] sl;
    sr = w >> (k * Lanes);
    sl = w << (k * Lanes);
    return lsb ? sr[Lanes-1:0] : sl[DataWidth-1 -: Lanes];
  endfunction

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    lsb_d       = lsb_q;
    beat_d      = beat_q;
    div_d       = div_q;
    hold_d      = hold_q;
    hold_lsb_d  = hold_lsb_q;
    hold_full_d = hold_full_q;
    hold_move   = 1'b0;

    accept     = start_i & ready_q;
    last_cycle = (state_q == StShift) && (beat_q == BeatLast) && (div_q == DivLast);

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          word_d  = data_i;
          lsb_d   = lsb_first_i;
          beat_d  = '0;
          div_d   = '0;
        end
      end
      default: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (beat_q == BeatLast) begin
            beat_d = '0;
            if (hold_full_q) begin
              word_d      = hold_q;
              lsb_d       = hold_lsb_q;
              hold_full_d = 1'b0;
              hold_move   = 1'b1;
            end else if (accept) begin
              word_d = data_i;
              lsb_d  = lsb_first_i;
            end else begin
              state_d = StIdle;
            end
          end else begin
            beat_d = beat_q + BeatOne;
          end
        end else begin
          div_d = div_q + DivOne;
        end
        // On the final cycle an accepted word bypasses the hold register.
        if (accept && !last_cycle) begin
          hold_d      = data_i;
          hold_lsb_d  = lsb_first_i;
          hold_full_d = 1'b1;
        end
      end
    endcase

    // Outputs are registered from next-state values so they line up with the beat in flight.
    busy_d  = (state_d == StShift);
    ena_d   = (state_d == StShift);
    data_d  = (state_d == StShift) ? beat_of(word_d, lsb_d, beat_d) : '0;
    done_d  = (state_d == StShift) && (beat_d == BeatLast) && (div_d == DivLast);
    ready_d = !(hold_full_d || hold_move);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      word_q      <= '0;
      lsb_q       <= 1'b0;
      beat_q      <= '0;
      div_q       <= '0;
      hold_q      <= '0;
      hold_lsb_q  <= 1'b0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      data_q      <= '0;
      ena_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      lsb_q       <= lsb_d;
      beat_q      <= beat_d;
      div_q       <= div_d;
      hold_q      <= hold_d;
      hold_lsb_q  <= hold_lsb_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      ena_q       <= ena_d;
      done_q      <= done_d;
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign data_o  = data_q;
  assign ena_o   = ena_q;
  assign done_o  = done_q;

endmodule
